bb_adc_scan_ctrl: RTL and testbench

- Sequencer for the multiplexed board-monitor ADC conversion FSM. Steps an analog mux through NCHAN channels, drives STROBE/READBB into the conversion FSM, and captures each result into a per-channel register file.
- Arbitrates between a periodic auto-scan and single-channel VME read requests.
- Sits between the VME register decoder and the conversion FSM.

---
 rtl/bb_adc_pkg.sv | 21 ++
 rtl/bb_adc_scan_ctrl_if.sv | 26 ++
 rtl/bb_adc_resfile.sv | 36 +++
 rtl/bb_adc_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bb_adc_scan_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bb_adc_pkg.sv
// Shared encodings for the board-monitor ADC scan sequencer: FSM states,
// request source and the result word written when a conversion is abandoned.
package bb_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAITDR  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        SRC_SCAN = 1'b0,
        SRC_VME  = 1'b1
    } src_t;

    localparam int DW_DEFAULT = 12;
    localparam logic [DW_DEFAULT-1:0] ERR_VALUE = '1;

endpackage

// File: rtl/bb_adc_scan_ctrl_if.sv
// Handshake between the scan sequencer (master) and the ADC conversion FSM (slave).
interface bb_adc_scan_ctrl_if
    import bb_adc_pkg::*;
#(
    parameter int CHW = 3,
    parameter int DW  = DW_DEFAULT
);

    logic           STROBE;
    logic           READBB;
    logic [CHW-1:0] MUXSEL;
    logic           ADCFSM_RST;
    logic           DATAREADY;
    logic [DW-1:0]  ADC_DATA;

    modport master (
        output STROBE, READBB, MUXSEL, ADCFSM_RST,
        input  DATAREADY, ADC_DATA
    );

    modport slave (
        input  STROBE, READBB, MUXSEL, ADCFSM_RST,
        output DATAREADY, ADC_DATA
    );

endinterface

// File: rtl/bb_adc_resfile.sv
// Per-channel result register file: one write port, one registered read port.
// A same-cycle write and read of one channel returns the old value.
module bb_adc_resfile
    import bb_adc_pkg::*;
#(
    parameter int  NCHAN = 8,
    parameter int  DW    = DW_DEFAULT,
    localparam int CHW   = $clog2(NCHAN)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic [CHW-1:0] rd_addr,
    output logic [DW-1:0]  rd_data
);

    logic [DW-1:0] mem [NCHAN];

    // Addresses beyond NCHAN-1 exist only when NCHAN is not a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCHAN; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en && (int'(wr_addr) < NCHAN)) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= (int'(rd_addr) < NCHAN) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/bb_adc_scan_ctrl.sv
// Board-monitor ADC scan sequencer: periodic auto-scan plus single-channel VME reads.
// Optional DATAREADY watchdog is built only when BB_SCAN_TIMEOUT_EN is defined.
module bb_adc_scan_ctrl
    import bb_adc_pkg::*;
#(
    parameter int  NCHAN       = 8,
    parameter int  DW          = DW_DEFAULT,
    parameter int  SETTLE_CYC  = 16,
    parameter int  SCAN_PERIOD = 65536,
`ifdef BB_SCAN_TIMEOUT_EN
    parameter int  TIMEOUT_CYC = 1024,
`endif
    localparam int CHW         = $clog2(NCHAN)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SCAN_EN,
    input  logic               VME_REQ,
    input  logic [CHW-1:0]     VME_CHAN,
    output logic               VME_ACK,
    output logic [DW-1:0]      VME_DATA,
    bb_adc_scan_ctrl_if.master adc,
    input  logic [CHW-1:0]     RD_CHAN,
    output logic [DW-1:0]      RD_DATA,
    output logic               BUSY,
    output logic               SCAN_DONE,
    output logic               TIMEOUT_ERR
);

    localparam int             PW         = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int             SW         = $clog2(SETTLE_CYC + 1);
    localparam logic [CHW-1:0] LAST_CHAN  = CHW'(NCHAN - 1);
    localparam logic [PW-1:0]  PERIOD_MAX = PW'(SCAN_PERIOD - 1);
    localparam logic [SW-1:0]  SETTLE_MAX = SW'(SETTLE_CYC - 1);

    state_t         state;
    src_t           src;
    logic [CHW-1:0] chan;
    logic [CHW-1:0] scan_ptr;
    logic           scan_pend;
    logic [PW-1:0]  period_cnt;
    logic [SW-1:0]  settle_cnt;
    logic           period_wrap;
    logic           timeout_hit;
    logic           wr_en;
    logic [DW-1:0]  wr_data;

    assign period_wrap = SCAN_EN && (period_cnt == PERIOD_MAX);
    assign BUSY        = (state != ST_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            period_cnt <= '0;
        end else if (!SCAN_EN || period_wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

`ifdef BB_SCAN_TIMEOUT_EN
    localparam int            TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (state == ST_WAITDR) && !adc.DATAREADY && (wait_cnt == TIMEOUT_MAX);

    // The watchdog resets the conversion FSM so RELEASE sees DATAREADY low and completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt       <= '0;
            TIMEOUT_ERR    <= 1'b0;
            adc.ADCFSM_RST <= 1'b0;
        end else begin
            adc.ADCFSM_RST <= timeout_hit;
            if (timeout_hit) begin
                TIMEOUT_ERR <= 1'b1;
            end
            if (state == ST_WAITDR) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit    = 1'b0;
    assign TIMEOUT_ERR    = 1'b0;
    assign adc.ADCFSM_RST = 1'b0;
`endif

    // A timed-out conversion is stored as all-ones through the normal write path.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = adc.ADC_DATA;
        if (state == ST_WAITDR) begin
            if (adc.DATAREADY) begin
                wr_en = 1'b1;
            end else if (timeout_hit) begin
                wr_en   = 1'b1;
                wr_data = {DW{ERR_VALUE[0]}};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            src        <= SRC_SCAN;
            chan       <= '0;
            scan_ptr   <= '0;
            scan_pend  <= 1'b0;
            settle_cnt <= '0;
            adc.STROBE <= 1'b0;
            adc.READBB <= 1'b0;
            adc.MUXSEL <= '0;
            VME_ACK    <= 1'b0;
            VME_DATA   <= '0;
            SCAN_DONE  <= 1'b0;
        end else begin
            VME_ACK   <= 1'b0;
            SCAN_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (VME_REQ) begin
                        src        <= SRC_VME;
                        chan       <= VME_CHAN;
                        adc.MUXSEL <= VME_CHAN;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else if (scan_pend) begin
                        scan_pend  <= 1'b0;
                        src        <= SRC_SCAN;
                        chan       <= scan_ptr;
                        adc.MUXSEL <= scan_ptr;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_MAX) begin
                        state <= ST_REQ;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    adc.STROBE <= 1'b1;
                    adc.READBB <= 1'b1;
                    state      <= ST_WAITDR;
                end
                ST_WAITDR: begin
                    if (wr_en) begin
                        adc.STROBE <= 1'b0;
                        adc.READBB <= 1'b0;
                        if (src == SRC_VME) begin
                            VME_DATA <= wr_data;
                        end
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A VME request arriving mid-scan is served between channels; scan_pend resumes the scan.
                    if (!adc.DATAREADY) begin
                        if (src == SRC_VME) begin
                            VME_ACK <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (chan != LAST_CHAN) begin
                            scan_ptr <= chan + 1'b1;
                            if (VME_REQ) begin
                                scan_pend <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                chan       <= chan + 1'b1;
                                adc.MUXSEL <= chan + 1'b1;
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end
                        end else begin
                            scan_ptr  <= '0;
                            SCAN_DONE <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (period_wrap) begin
                scan_pend <= 1'b1;
            end
        end
    end

    bb_adc_resfile #(
        .NCHAN (NCHAN),
        .DW    (DW)
    ) u_resfile (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_addr (chan),
        .wr_data (wr_data),
        .rd_addr (RD_CHAN),
        .rd_data (RD_DATA)
    );

endmodule

// File: tb/tb_bb_adc_scan_ctrl.sv
// Directed bench for bb_adc_scan_ctrl with a behavioural conversion-FSM model.
// Covers the BB_SCAN_TIMEOUT_EN watchdog when that macro is defined.
module tb_bb_adc_scan_ctrl;

    localparam int NCHAN       = 4;
    localparam int DW          = 12;
    localparam int CHW         = 2;
    localparam int SETTLE_CYC  = 4;
    localparam int SCAN_PERIOD = 64;
`ifdef BB_SCAN_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 32;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic           SCAN_EN;
    logic           VME_REQ;
    logic [CHW-1:0] VME_CHAN;
    logic           VME_ACK;
    logic [DW-1:0]  VME_DATA;
    logic [CHW-1:0] RD_CHAN;
    logic [DW-1:0]  RD_DATA;
    logic           BUSY;
    logic           SCAN_DONE;
    logic           TIMEOUT_ERR;

    bb_adc_scan_ctrl_if #(.CHW(CHW), .DW(DW)) adc ();

    bb_adc_scan_ctrl #(
        .NCHAN       (NCHAN),
        .DW          (DW),
        .SETTLE_CYC  (SETTLE_CYC),
`ifdef BB_SCAN_TIMEOUT_EN
        .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
        .SCAN_PERIOD (SCAN_PERIOD)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCAN_EN     (SCAN_EN),
        .VME_REQ     (VME_REQ),
        .VME_CHAN    (VME_CHAN),
        .VME_ACK     (VME_ACK),
        .VME_DATA    (VME_DATA),
        .adc         (adc),
        .RD_CHAN     (RD_CHAN),
        .RD_DATA     (RD_DATA),
        .BUSY        (BUSY),
        .SCAN_DONE   (SCAN_DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int adcrst_cnt = 0;
    int strobe_rise_cyc = 0;
    int strobe_fall_cyc = 0;
    int dr_rise_cyc = 0;
    int mux_chg_cyc = 0;
    logic           strobe_q = 1'b0;
    logic           dr_q = 1'b0;
    logic [CHW-1:0] mux_q = '0;
    logic [CHW-1:0] mux_log [$];

    logic          model_on = 1'b1;
    int            dr_delay = 5;
    int            dr_hold  = 1;
    int            model_cnt = 0;
    int            hold_cnt = 0;
    logic [DW-1:0] adc_value [NCHAN];

    // Conversion-FSM model: DATAREADY some cycles after STROBE, data scrambled after the first cycle.
    always @(negedge CLK) begin
        if (RST || !model_on) begin
            adc.DATAREADY = 1'b0;
            model_cnt = 0;
            hold_cnt = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            adc.ADC_DATA = adc.ADC_DATA ^ 12'h5A5;
            if (hold_cnt == 0) adc.DATAREADY = 1'b0;
        end else if (adc.STROBE) begin
            model_cnt++;
            if (model_cnt == dr_delay) begin
                adc.DATAREADY = 1'b1;
                adc.ADC_DATA  = adc_value[adc.MUXSEL];
                hold_cnt = dr_hold;
                model_cnt = 0;
            end
        end else begin
            model_cnt = 0;
        end
    end

    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        if (SCAN_DONE) done_cnt++;
        if (VME_ACK) ack_cnt++;
        if (adc.ADCFSM_RST) adcrst_cnt++;
        if (adc.STROBE && !strobe_q) begin
            mux_log.push_back(adc.MUXSEL);
            strobe_rise_cyc = cyc;
        end
        if (!adc.STROBE && strobe_q) strobe_fall_cyc = cyc;
        if (adc.DATAREADY && !dr_q) dr_rise_cyc = cyc;
        if (adc.MUXSEL != mux_q) mux_chg_cyc = cyc;
        strobe_q = adc.STROBE;
        dr_q = adc.DATAREADY;
        mux_q = adc.MUXSEL;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic scan_en_v, input logic vme_req_v, input logic [CHW-1:0] vme_chan_v);
        SCAN_EN  = scan_en_v;
        VME_REQ  = vme_req_v;
        VME_CHAN = vme_chan_v;
    endtask

    task automatic readResult(input logic [CHW-1:0] ch, output logic [DW-1:0] val);
        RD_CHAN = ch;
        @(posedge CLK);
        #1;
        val = RD_DATA;
    endtask

    task automatic checkResults(input string tag, input int base, input int step);
        logic [DW-1:0] v;
        for (int i = 0; i < NCHAN; i++) begin
            readResult(CHW'(i), v);
            checkOutput($sformatf("%s_res%0d", tag, i), 32'(v), 32'(base + step * i));
        end
    endtask

    // Runs the period counter only until the scan starts, so exactly one scan is pending.
    task automatic startScan(input string tag);
        bit seen = 0;
        applyStimulus(1'b1, VME_REQ, VME_CHAN);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge CLK);
            #1;
            seen = BUSY;
        end
        applyStimulus(1'b0, VME_REQ, VME_CHAN);
        checkOutput($sformatf("%s_started", tag), 32'(seen), 32'd1);
    endtask

    task automatic waitDone(input string tag, input int target);
        bit hit = 0;
        for (int i = 0; i < 800 && !hit; i++) begin
            @(posedge CLK);
            #1;
            hit = (done_cnt >= target);
        end
        checkOutput($sformatf("%s_done_seen", tag), 32'(hit), 32'd1);
    endtask

    task automatic vmeRequest(input string tag, input logic [CHW-1:0] ch);
        bit seen = 0;
        applyStimulus(SCAN_EN, 1'b1, ch);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge CLK);
            #1;
            seen = VME_ACK;
        end
        applyStimulus(SCAN_EN, 1'b0, ch);
        checkOutput($sformatf("%s_ack_seen", tag), 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done0;
        int ack0;
        bit seen;
        logic [DW-1:0] v;
        int exp3 [5] = '{0, 1, 0, 2, 3};

        applyStimulus(1'b0, 1'b0, '0);
        RD_CHAN = '0;
        adc.DATAREADY = 1'b0;
        adc.ADC_DATA  = '0;
        for (int i = 0; i < NCHAN; i++) adc_value[i] = DW'(12'h100 + i);

        RST = 1'b0;
        #3 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_busy",       32'(BUSY),           32'd0);
        checkOutput("rst_strobe",     32'(adc.STROBE),     32'd0);
        checkOutput("rst_readbb",     32'(adc.READBB),     32'd0);
        checkOutput("rst_muxsel",     32'(adc.MUXSEL),     32'd0);
        checkOutput("rst_vme_ack",    32'(VME_ACK),        32'd0);
        checkOutput("rst_vme_data",   32'(VME_DATA),       32'd0);
        checkOutput("rst_rd_data",    32'(RD_DATA),        32'd0);
        checkOutput("rst_scan_done",  32'(SCAN_DONE),      32'd0);
        checkOutput("rst_timeout",    32'(TIMEOUT_ERR),    32'd0);
        checkOutput("rst_adcfsm_rst", 32'(adc.ADCFSM_RST), 32'd0);
        RST = 1'b0;
        checkResults("rst", 0, 0);

        // Plain auto-scan of all channels.
        mux_log.delete();
        done0 = done_cnt;
        startScan("scan1");
        waitDone("scan1", done0 + 1);
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("scan1_done_pulses", 32'(done_cnt - done0), 32'd1);
        checkOutput("scan1_mux_count", 32'(mux_log.size()), 32'd4);
        for (int i = 0; i < mux_log.size() && i < 4; i++)
            checkOutput($sformatf("scan1_mux%0d", i), 32'(mux_log[i]), 32'(i));
        checkOutput("scan1_idle", 32'(BUSY), 32'd0);
        checkResults("scan1", 'h100, 1);

        // VME read of channel 2 with DATAREADY held three cycles.
        adc_value[2] = 12'hABC;
        dr_hold = 3;
        ack0 = ack_cnt;
        vmeRequest("vme2", 2'd2);
        repeat (5) @(posedge CLK);
        #1;
        dr_hold = 1;
        checkOutput("vme2_ack_pulses",  32'(ack_cnt - ack0), 32'd1);
        checkOutput("vme2_data",        32'(VME_DATA), 32'hABC);
        checkOutput("vme2_strobe_fall", 32'(strobe_fall_cyc), 32'(dr_rise_cyc));
        checkOutput("vme2_settle",      32'(strobe_rise_cyc - mux_chg_cyc), 32'(SETTLE_CYC + 1));
        checkOutput("vme2_readbb",      32'(adc.READBB), 32'd0);
        readResult(2'd2, v);
        checkOutput("vme2_res2", 32'(v), 32'hABC);

        // VME request arriving while scan channel 1 converts.
        for (int i = 0; i < NCHAN; i++) adc_value[i] = DW'(12'h200 + i);
        mux_log.delete();
        done0 = done_cnt;
        ack0 = ack_cnt;
        startScan("scan3");
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge CLK);
            #1;
            seen = adc.STROBE && (adc.MUXSEL == 2'd1);
        end
        checkOutput("scan3_ch1_strobe", 32'(seen), 32'd1);
        vmeRequest("vme3", 2'd0);
        waitDone("scan3", done0 + 1);
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("scan3_done_pulses", 32'(done_cnt - done0), 32'd1);
        checkOutput("scan3_ack_pulses",  32'(ack_cnt - ack0), 32'd1);
        checkOutput("scan3_vme_data",    32'(VME_DATA), 32'h200);
        checkOutput("scan3_mux_count",   32'(mux_log.size()), 32'd5);
        for (int i = 0; i < mux_log.size() && i < 5; i++)
            checkOutput($sformatf("scan3_mux%0d", i), 32'(mux_log[i]), 32'(exp3[i]));
        checkResults("scan3", 'h200, 1);

`ifdef BB_SCAN_TIMEOUT_EN
        // Converter never answers: watchdog must abandon the conversion.
        model_on = 1'b0;
        ack0 = ack_cnt;
        done0 = adcrst_cnt;
        vmeRequest("tmo", 2'd3);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("tmo_strobe_width", 32'(strobe_fall_cyc - strobe_rise_cyc), 32'(TIMEOUT_CYC));
        checkOutput("tmo_adcfsm_rst",   32'(adcrst_cnt - done0), 32'd1);
        checkOutput("tmo_err",          32'(TIMEOUT_ERR), 32'd1);
        checkOutput("tmo_vme_data",     32'(VME_DATA), 32'hFFF);
        checkOutput("tmo_ack_pulses",   32'(ack_cnt - ack0), 32'd1);
        readResult(2'd3, v);
        checkOutput("tmo_res3", 32'(v), 32'hFFF);
        model_on = 1'b1;
`else
        checkOutput("tmo_err_tied",    32'(TIMEOUT_ERR), 32'd0);
        checkOutput("adcfsm_rst_none", 32'(adcrst_cnt),  32'd0);
`endif

        // Asynchronous reset while waiting for DATAREADY.
        model_on = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'd1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge CLK);
            #1;
            seen = adc.STROBE;
        end
        checkOutput("arst_strobe_up", 32'(seen), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'd1);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        checkOutput("arst_strobe", 32'(adc.STROBE), 32'd0);
        checkOutput("arst_readbb", 32'(adc.READBB), 32'd0);
        checkOutput("arst_busy",   32'(BUSY),       32'd0);
        @(posedge CLK);
        #1;
        checkOutput("arst_vme_data", 32'(VME_DATA),    32'd0);
        checkOutput("arst_timeout",  32'(TIMEOUT_ERR), 32'd0);
        RST = 1'b0;
        model_on = 1'b1;
        checkResults("arst", 0, 0);

        for (int i = 0; i < NCHAN; i++) adc_value[i] = DW'(12'h300 + i);
        done0 = done_cnt;
        startScan("scan5");
        waitDone("scan5", done0 + 1);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("scan5_done_pulses", 32'(done_cnt - done0), 32'd1);
        checkResults("scan5", 'h300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
